// File: rtl/burst_pkg.sv
// rtl/burst_pkg.sv - shared FSM encoding, defaults and address helper for the burst writer
package burst_pkg;

  localparam int WORDS_DEFAULT     = 16;
  localparam int ADDR_STEP_DEFAULT = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Address of word idx; the 32-bit sum wraps silently past 0xFFFFFFFF.
  function automatic logic [31:0] word_addr(logic [31:0] base, logic [31:0] idx,
                                            logic [31:0] step);
    return base + idx * step;
  endfunction

endpackage

// File: rtl/burst_addr_counter.sv
// rtl/burst_addr_counter.sv - word index register and base + index*step address generation
module burst_addr_counter
  import burst_pkg::*;
#(
  parameter int WORDS     = WORDS_DEFAULT,
  parameter int ADDR_STEP = ADDR_STEP_DEFAULT,
  parameter int IDX_W     = $clog2(WORDS)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [31:0]      base_i,
  output logic [IDX_W-1:0] index_o,
  output logic [31:0]      addr_o
);

  logic [31:0]      base_q, base_d;
  logic [IDX_W-1:0] index_q, index_d;

  always_comb begin
    base_d  = base_q;
    index_d = index_q;
    if (load_i) begin
      base_d  = base_i;
      index_d = '0;
    end else if (step_i) begin
      index_d = index_q + IDX_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      base_q  <= '0;
      index_q <= '0;
    end else begin
      base_q  <= base_d;
      index_q <= index_d;
    end
  end

  assign index_o = index_q;
  assign addr_o  = word_addr(base_q, 32'(index_q), 32'(ADDR_STEP));

endmodule

// File: rtl/burst_writer.sv
// rtl/burst_writer.sv - writes one latched WORDS-word line to memory with valid/ready handshakes
module burst_writer
  import burst_pkg::*;
#(
  parameter int WORDS     = WORDS_DEFAULT,
  parameter int ADDR_STEP = ADDR_STEP_DEFAULT
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [31:0]           base_address,
  input  logic [32*WORDS-1:0]   line_data,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_w_valid,
  input  logic                  mem_w_ready,
  output logic [31:0]           mem_w_address,
  output logic [31:0]           mem_w_data
);

  localparam int IDX_W = $clog2(WORDS);

  logic [1:0]          state_q, state_d;
  logic                valid_q, valid_d;
  logic [31:0]         data_q, data_d;
  logic [32*WORDS-1:0] payload_q;
  logic [IDX_W-1:0]    index;
  logic [IDX_W-1:0]    index_nx;
  logic                load;
  logic                step;
  logic                last;

  assign load     = (state_q == ST_IDLE) && start;
  assign step     = valid_q && mem_w_ready;
  assign last     = (index == IDX_W'(WORDS - 1));
  assign index_nx = index + IDX_W'(1);

  burst_addr_counter #(
    .WORDS     (WORDS),
    .ADDR_STEP (ADDR_STEP),
    .IDX_W     (IDX_W)
  ) u_addr_counter (
    .clk_i   (clk),
    .rst_i   (rst),
    .load_i  (load),
    .step_i  (step),
    .base_i  (base_address),
    .index_o (index),
    .addr_o  (mem_w_address)
  );

  // Data is registered alongside the index so it is held while ready is low.
  always_comb begin
    state_d = state_q;
    valid_d = valid_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WRITE;
          valid_d = 1'b1;
          data_d  = line_data[31:0];
        end
      end
      ST_WRITE: begin
        if (step) begin
          data_d = payload_q[32*index_nx +: 32];
          if (last) begin
            state_d = ST_DONE;
            valid_d = 1'b0;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  always_ff @(posedge clk) begin
    if (load) begin
      payload_q <= line_data;
    end
  end

  assign busy        = (state_q != ST_IDLE);
  assign done        = (state_q == ST_DONE);
  assign mem_w_valid = valid_q;
  assign mem_w_data  = data_q;

endmodule
